// File: rtl/sec_a2b_iter_if.sv
`default_nettype none
// ============================================================================
//  Module      : sec_a2b_iter_if
//  Description : Handshake/data bundle for the iterative masked A2B converter.
//                The master drives the start request, the arithmetic shares and
//                the fresh randomness. The slave returns busy, the Boolean
//                shares and the one-cycle valid pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
interface sec_a2b_iter_if #(
    parameter int K_WIDTH  = 32,
    parameter int N_SHARES = 4,
    parameter int RND_W    = N_SHARES * (N_SHARES - 1)
);
    // A single-share build consumes no randomness; keep one dummy bit.
    localparam int RND_PW = (RND_W > 0) ? RND_W : 1;

    logic                          dvld;
    logic [K_WIDTH*N_SHARES-1:0]   i_a;
    logic [RND_PW-1:0]             rnd;
    logic                          busy;
    logic [K_WIDTH*N_SHARES-1:0]   o_b;
    logic                          ovld;

    modport master (
        output dvld,
        output i_a,
        output rnd,
        input  busy,
        input  o_b,
        input  ovld
    );

    modport slave (
        input  dvld,
        input  i_a,
        input  rnd,
        output busy,
        output o_b,
        output ovld
    );
endinterface
`default_nettype wire

// File: rtl/sec_a2b_iter.sv
`default_nettype none
// ============================================================================
//  Module      : sec_a2b_iter
//  Description : Iterative masked arithmetic-to-Boolean converter. The
//                arithmetic shares are added one at a time into a Boolean-
//                masked accumulator through a bit-serial masked ripple adder
//                (two ISW AND gadgets for generate/propagate).
//                Optional macro SEC_A2B_ITER_CLR_EN: zeroize o_b, A, B, C on
//                the edge after the ovld cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module sec_a2b_iter #(
    parameter int K_WIDTH  = 32,
    parameter int N_SHARES = 4,
    parameter int RND_W    = N_SHARES * (N_SHARES - 1)
) (
    input  wire logic        clk,
    input  wire logic        rst,
    sec_a2b_iter_if.slave    bus_if
);
    localparam int RND_PW = (RND_W > 0) ? RND_W : 1;
    localparam int HALF   = RND_W / 2;
    localparam int JW     = (K_WIDTH  > 1) ? $clog2(K_WIDTH)  : 1;
    localparam int IW     = (N_SHARES > 1) ? $clog2(N_SHARES) : 1;
    localparam logic [JW-1:0] J_LAST = JW'(K_WIDTH - 1);
    localparam logic [IW-1:0] I_LAST = IW'(N_SHARES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADD  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                             state_q;
    logic [N_SHARES-1:0][K_WIDTH-1:0]   a_q;
    logic [N_SHARES-1:0][K_WIDTH-1:0]   b_q;
    logic [N_SHARES-1:0]                c_q;
    logic [IW-1:0]                      i_q;
    logic [JW-1:0]                      j_q;
    logic                               busy_q;
    logic                               ovld_q;
    logic [N_SHARES-1:0][K_WIDTH-1:0]   o_b_q;

    logic [N_SHARES-1:0]                x_w;
    logic [N_SHARES-1:0]                y_w;
    logic [N_SHARES-1:0]                xy_w;
    logic [N_SHARES-1:0]                g_w;
    logic [N_SHARES-1:0]                p_w;
    logic [N_SHARES-1:0]                carry_d;
    logic [N_SHARES-1:0][K_WIDTH-1:0]   b_d;

    // ISW multiplication on N Boolean shares. Pair (u,v), u<v, takes random
    // bit r[base + lexicographic pair index]; the cross term is folded into
    // r before adding the mirrored product so no unmasked partial appears.
    function automatic logic [N_SHARES-1:0] isw_and(
        input logic [N_SHARES-1:0] a,
        input logic [N_SHARES-1:0] b,
        input logic [RND_PW-1:0]   r,
        input int                  base
    );
        logic [N_SHARES-1:0] z;
        logic                rr;
        int                  pidx;
        z    = a & b;
        pidx = 0;
        for (int u = 0; u < N_SHARES; u++) begin
            for (int v = u + 1; v < N_SHARES; v++) begin
                rr   = r[base + pidx];
                z[u] = z[u] ^ rr;
                z[v] = z[v] ^ ((rr ^ (a[u] & b[v])) ^ (a[v] & b[u]));
                pidx = pidx + 1;
            end
        end
        return z;
    endfunction

    // One masked full-adder step on bit j: sum into B, generate/propagate carry.
    always_comb begin
        x_w  = '0;
        y_w  = '0;
        b_d  = b_q;
        for (int s = 0; s < N_SHARES; s++) begin
            x_w[s] = b_q[s][j_q];
        end
        // Addend is (a_i, 0, ..., 0): only share 0 carries its bit.
        y_w[0]  = a_q[i_q][j_q];
        xy_w    = x_w ^ y_w;
        for (int s = 0; s < N_SHARES; s++) begin
            b_d[s][j_q] = xy_w[s] ^ c_q[s];
        end
        g_w     = isw_and(x_w, y_w,  bus_if.rnd, 0);
        p_w     = isw_and(c_q, xy_w, bus_if.rnd, HALF);
        carry_d = g_w ^ p_w;
    end

    // Control FSM and datapath registers; all outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            i_q     <= '0;
            j_q     <= '0;
            busy_q  <= 1'b0;
            ovld_q  <= 1'b0;
            o_b_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    ovld_q <= 1'b0;
                    if (bus_if.dvld) begin
                        a_q     <= bus_if.i_a;
                        b_q     <= '0;
                        b_q[0]  <= bus_if.i_a[K_WIDTH-1:0];
                        c_q     <= '0;
                        i_q     <= IW'(1);
                        j_q     <= '0;
                        busy_q  <= 1'b1;
                        if (N_SHARES == 1) begin
                            // Nothing to add: a0 alone is already Boolean.
                            state_q <= S_DONE;
                            ovld_q  <= 1'b1;
                            o_b_q   <= '0;
                            o_b_q[0] <= bus_if.i_a[K_WIDTH-1:0];
                        end else begin
                            state_q <= S_ADD;
                        end
                    end
                end
                S_ADD: begin
                    b_q <= b_d;
                    if (j_q != J_LAST) begin
                        j_q <= j_q + JW'(1);
                        c_q <= carry_d;
                    end else begin
                        // Carry out of the MSB is dropped: arithmetic is mod 2^K.
                        c_q <= '0;
                        j_q <= '0;
                        if (i_q == I_LAST) begin
                            state_q <= S_DONE;
                            ovld_q  <= 1'b1;
                            o_b_q   <= b_d;
                        end else begin
                            i_q <= i_q + IW'(1);
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    ovld_q  <= 1'b0;
                    busy_q  <= 1'b0;
`ifdef SEC_A2B_ITER_CLR_EN
                    o_b_q   <= '0;
                    a_q     <= '0;
                    b_q     <= '0;
                    c_q     <= '0;
`endif
                end
                default: begin
                    state_q <= S_IDLE;
                    ovld_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus_if.busy = busy_q;
    assign bus_if.ovld = ovld_q;
    assign bus_if.o_b  = o_b_q;

endmodule
`default_nettype wire

// File: tb/tb_sec_a2b_iter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sec_a2b_iter
//  Description : Self-checking bench for sec_a2b_iter. Main instance N=4,
//                K=32; second instance N=1. The reference is the plain
//                modular sum of the arithmetic shares, compared against the
//                XOR of the returned Boolean shares.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sec_a2b_iter;
    localparam int K  = 32;
    localparam int N  = 4;
    localparam int LAT = 1 + (N - 1) * K;   // 97
    localparam int TMO = 200;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    sec_a2b_iter_if #(.K_WIDTH(K), .N_SHARES(N)) u_if ();
    sec_a2b_iter_if #(.K_WIDTH(K), .N_SHARES(1)) u_if1 ();

    sec_a2b_iter #(.K_WIDTH(K), .N_SHARES(N)) u_dut (
        .clk    (clk),
        .rst    (rst),
        .bus_if (u_if.slave)
    );

    sec_a2b_iter #(.K_WIDTH(K), .N_SHARES(1)) u_dut1 (
        .clk    (clk),
        .rst    (rst),
        .bus_if (u_if1.slave)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: arithmetic masking means the secret is the modular sum.
    function automatic logic [31:0] arith_sum(input logic [127:0] a);
        logic [31:0] s;
        s = '0;
        for (int k = 0; k < N; k++) s = s + a[k*K +: K];
        return s;
    endfunction

    function automatic logic [31:0] bool_xor(input logic [127:0] b);
        logic [31:0] x;
        x = '0;
        for (int k = 0; k < N; k++) x = x ^ b[k*K +: K];
        return x;
    endfunction

    // Start a conversion, wait (bounded) for ovld; returns latency and o_b.
    task automatic convert(input logic [127:0] a, input bit rnd_rand,
                           output int lat, output logic [127:0] ob, output bit busy_ok);
        u_if.i_a  = a;
        u_if.dvld = 1'b1;
        u_if.rnd  = rnd_rand ? 12'($urandom) : 12'h0;
        tick();
        u_if.dvld = 1'b0;
        u_if.i_a  = {$urandom, $urandom, $urandom, $urandom};
        lat     = 1;
        busy_ok = 1'b1;
        while (!u_if.ovld && lat < TMO) begin
            if (!u_if.busy) busy_ok = 1'b0;
            u_if.rnd = rnd_rand ? 12'($urandom) : 12'h0;
            tick();
            lat++;
        end
        if (!u_if.busy) busy_ok = 1'b0;
        ob = u_if.o_b;
    endtask

    int           lat;
    int           n_ovld;
    bit           bok;
    logic [127:0] ob, ob2, va, vb;

    initial begin
        rst        = 1'b1;
        u_if.dvld  = 1'b0;
        u_if.i_a   = '0;
        u_if.rnd   = '0;
        u_if1.dvld = 1'b0;
        u_if1.i_a  = '0;
        u_if1.rnd  = '0;
        tick();
        tick();
        chk("reset_busy", 128'(u_if.busy), 128'd0);
        chk("reset_ovld", 128'(u_if.ovld), 128'd0);
        chk("reset_ob",   u_if.o_b,        128'd0);
        rst = 1'b0;
        tick();

        // Directed vector, no randomness.
        va = {32'h00000001, 32'hFFFFFFFF, 32'h11111111, 32'h12345678};
        convert(va, 1'b0, lat, ob, bok);
        chk("dir_lat",  128'(lat), 128'(LAT));
        chk("dir_xor",  128'(bool_xor(ob)), 128'h23456789);
        chk("dir_busy", 128'(bok), 128'd1);
        tick();
        chk("dir_busy_drop", 128'(u_if.busy), 128'd0);
        chk("dir_ovld_drop", 128'(u_if.ovld), 128'd0);
        // Hold / zeroize behaviour of o_b after the result.
`ifdef SEC_A2B_ITER_CLR_EN
        chk("clr_ob", u_if.o_b, 128'd0);
`else
        for (int k = 0; k < 4; k++) tick();
        chk("hold_ob", u_if.o_b, ob);
`endif

        // Wrap-around: carry out of bit 31 is dropped.
        va = {32'h0, 32'h0, 32'h00000001, 32'hFFFFFFFF};
        convert(va, 1'b1, lat, ob, bok);
        chk("wrap_lat", 128'(lat), 128'(LAT));
        chk("wrap_xor", 128'(bool_xor(ob)), 128'h0);
        tick();

        // Same input, different randomness: shares must differ, value must not.
        va = {32'h00000001, 32'hFFFFFFFF, 32'h11111111, 32'h12345678};
        convert(va, 1'b1, lat, ob, bok);
        tick();
        convert(va, 1'b1, lat, ob2, bok);
        chk("rnd_xor", 128'(bool_xor(ob2)), 128'h23456789);
        chk("rnd_shares_differ", 128'(ob != ob2), 128'd1);
        tick();

        // Random vectors with random fresh randomness.
        for (int n = 0; n < 150; n++) begin
            va = {$urandom, $urandom, $urandom, $urandom};
            convert(va, 1'b1, lat, ob, bok);
            chk("rand_lat", 128'(lat), 128'(LAT));
            chk("rand_xor", 128'(bool_xor(ob)), 128'(arith_sum(va)));
            tick();
        end

        // dvld while busy (t+10) and in the DONE cycle must be ignored.
        va = {$urandom, $urandom, $urandom, $urandom};
        vb = {$urandom, $urandom, $urandom, $urandom};
        u_if.i_a  = va;
        u_if.dvld = 1'b1;
        tick();
        n_ovld = 0;
        for (int c = 1; c <= 120; c++) begin
            u_if.rnd = 12'($urandom);
            if (u_if.ovld) begin
                n_ovld++;
                ob = u_if.o_b;
            end
            u_if.dvld = (c == 10) || u_if.ovld;
            u_if.i_a  = vb;
            tick();
        end
        u_if.dvld = 1'b0;
        chk("ign_ovld_count", 128'(n_ovld), 128'd1);
        chk("ign_xor", 128'(bool_xor(ob)), 128'(arith_sum(va)));
        chk("ign_idle", 128'(u_if.busy), 128'd0);

        // Reset in the middle of ADD.
        u_if.i_a  = va;
        u_if.dvld = 1'b1;
        tick();
        u_if.dvld = 1'b0;
        for (int c = 1; c < 40; c++) begin
            u_if.rnd = 12'($urandom);
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mrst_busy", 128'(u_if.busy), 128'd0);
        chk("mrst_ovld", 128'(u_if.ovld), 128'd0);
        chk("mrst_ob",   u_if.o_b,        128'd0);
        n_ovld = 0;
        for (int c = 0; c < 110; c++) begin
            if (u_if.ovld) n_ovld++;
            tick();
        end
        chk("mrst_no_ovld", 128'(n_ovld), 128'd0);
        convert(vb, 1'b1, lat, ob, bok);
        chk("mrst_after_lat", 128'(lat), 128'(LAT));
        chk("mrst_after_xor", 128'(bool_xor(ob)), 128'(arith_sum(vb)));
        tick();

        // Single-share build: passthrough after one cycle.
        u_if1.i_a  = 32'hCAFEBABE;
        u_if1.dvld = 1'b1;
        tick();
        u_if1.dvld = 1'b0;
        chk("n1_ovld", 128'(u_if1.ovld), 128'd1);
        chk("n1_busy", 128'(u_if1.busy), 128'd1);
        chk("n1_ob",   128'(u_if1.o_b),  128'hCAFEBABE);
        tick();
        chk("n1_ovld_drop", 128'(u_if1.ovld), 128'd0);
        chk("n1_busy_drop", 128'(u_if1.busy), 128'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
